alu_req_driver: RTL and testbench
=================================

// Module: alu_req_driver
// PURPOSE
//  Initiator side of the ALU interface. Accepts tagged commands over valid/ready, drives alu_A/alu_B/alu_opcode
//  and samples alu_Result/alu_Error two edges later. Returns tagged responses through a credit-guarded response FIFO.
//  Filters illegal opcodes locally and converts the ALU's sticky Error into a per-operation error bit.
// PARAMETERS
//  DEPTH    4       response FIFO entries = max commands in flight + queued (power of 2, >=2)
//  TAG_W    4       command/response tag width
//  IDLE_OP  3'b010  opcode driven when no command issues (AND of zeros; never sets ALU Error)
// PORTS
//  clk         in   1      clock; all state changes on its rising edge
//  rst         in   1      asynchronous, active-high reset
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      command accepted when cmd_valid && cmd_ready at a rising edge
//  cmd_a       in   32     operand A, signed
//  cmd_b       in   32     operand B
//  cmd_op      in   3      000 add, 001 sub, 010 and, 011 or, 100 xor; 101-111 illegal
//  cmd_tag     in   TAG_W  returned unchanged with the response
//  alu_A       out  32     ALU operand 1, registered
//  alu_B       out  32     ALU operand 2, registered
//  alu_opcode  out  3      ALU opcode, registered
//  alu_Result  in   32     ALU registered result
//  alu_Error   in   1      ALU error flag; sticky until rst
//  rsp_valid   out  1      FIFO head valid
//  rsp_ready   in   1      head popped when rsp_valid && rsp_ready at a rising edge
//  rsp_result  out  32     result; 0 for an illegal opcode
//  rsp_error   out  1      error caused by this operation
//  rsp_tag     out  TAG_W  tag of this response
//  err_sticky  out  1      alu_Error seen since reset, or any illegal opcode accepted
// BEHAVIOUR
//  Reset: alu_A=0, alu_B=0, alu_opcode=IDLE_OP; FIFO empty; rsp_valid=0; err_sticky=0; credits=0; pipe empty.
//    rsp_result/rsp_error/rsp_tag read 0 while empty. Reset mid-operation drops all in-flight ops and queued rsps.
//  credits = ops in pipe + FIFO occupancy. cmd_ready = (credits < DEPTH), combinational from registers only.
//    Accept without pop: credits+1. Pop without accept: credits-1. Both in the same cycle: credits unchanged.
//  Legal accept at edge E0:
//    - alu_A/alu_B/alu_opcode load cmd_a/cmd_b/cmd_op.
//    - Pipe stage s1 loads {1, tag, legal=1}.
//    - The ALU registers the result at E1, while s1 moves to s2.
//    - At E2 the FIFO pushes {alu_Result, alu_Error & ~err_seen, tag}; err_seen |= alu_Error.
//  Illegal opcode: alu_* load {0,0,IDLE_OP} and never issue the opcode. s1 = {1, tag, legal=0}.
//    At E2 push {0, 1, tag}; err_sticky sets.
//  No accept at an edge: alu_* load {0,0,IDLE_OP}; s1 loads invalid.
//  Throughput: 1 cmd/cycle sustained. Latency: accept edge to rsp_valid high = 2 edges when FIFO empty and rsp_ready=1.
//  Responses return in acceptance order. The FIFO never overflows: credits guarantee a slot for every pipe entry.
//  Pointers are log2(DEPTH)+1 bits; wrap-around uses the MSB for full/empty.
//  err_sticky = err_seen | illegal-seen; clears only on rst.
//  After the first add/sub overflow, later ops report rsp_error=0 (alu_Error stays 1); err_sticky stays 1.
//  Overflow detection is the ALU's; rsp_result is the 32-bit wrapped value.
// TESTING
//  1. add A=5 B=7 tag=3, rsp_ready=1 -> 2 edges later rsp_valid=1, result=12, error=0, tag=3.
//  2. add A=32'h7FFF_FFFF B=1 tag=1, then xor A=F0 B=FF tag=2
//     -> rsp1 result=8000_0000 error=1; rsp2 result=0F error=0; err_sticky=1.
//  3. rsp_ready=0, send 6 back-to-back and ops -> cmd_ready drops after 4 accepts. Release rsp_ready
//     -> 4 rsps in tag order; pop+accept same cycle holds credits.
//  4. cmd_op=3'b110 tag=7 -> alu_opcode never 110; rsp result=0 error=1 tag=7; the next add 2+2 returns 4 error=0.
//  5. rst asserted with 2 ops in flight and 1 queued -> next cycle rsp_valid=0, cmd_ready=1,
//     alu_opcode=IDLE_OP, err_sticky=0.
//  6. 20 random legal ops, random rsp_ready -> every rsp matches the reference model, order kept.

Source files
------------

// File: rtl/alu_req_driver.sv
`timescale 1ns/1ps
// Initiator side of the ALU interface: issues tagged commands to a two-edge ALU and
// returns tagged responses in order through a credit-guarded response FIFO.
module alu_req_driver #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter logic [2:0]  IDLE_OP = 3'b010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_A,
    output logic [31:0]      alu_B,
    output logic [2:0]       alu_opcode,
    input  logic [31:0]      alu_Result,
    input  logic             alu_Error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_error,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             err_sticky
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [DW-1:0]    result;
        logic             error;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    typedef struct packed {
        logic             valid;
        logic             legal;
        logic [TAG_W-1:0] tag;
    } stage_t;

    logic          accept;
    logic          pop;
    logic          push;
    logic          cmd_legal;
    logic          empty;
    stage_t        s1;
    stage_t        s2;
    rsp_t          mem [DEPTH];
    rsp_t          push_data;
    rsp_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] credits;
    logic          err_seen;
    logic          illegal_seen;

    // Credits count every accepted command not yet popped, so a FIFO slot always exists.
    assign cmd_ready = credits < PW'(DEPTH);
    assign accept    = cmd_valid & cmd_ready;
    assign cmd_legal = cmd_op <= 3'd4;
    assign empty     = wr_ptr == rd_ptr;
    assign rsp_valid = ~empty;
    assign pop       = rsp_valid & rsp_ready;
    assign push      = s2.valid;
    assign head      = mem[rd_ptr[AW-1:0]];

    assign rsp_result = empty ? '0 : head.result;
    assign rsp_error  = empty ? 1'b0 : head.error;
    assign rsp_tag    = empty ? '0 : head.tag;
    assign err_sticky = err_seen | illegal_seen;

    // ALU drive: illegal opcodes and idle cycles issue a harmless AND of zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= IDLE_OP;
        end else if (accept && cmd_legal) begin
            alu_A      <= cmd_a;
            alu_B      <= cmd_b;
            alu_opcode <= cmd_op;
        end else begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= IDLE_OP;
        end
    end

    // Two-stage tag pipe tracking the ALU's register latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= '{valid: accept, legal: cmd_legal, tag: cmd_tag};
            s2 <= s1;
        end
    end

    // ALU Error is sticky; only its first rise is charged to an operation.
    always_comb begin
        push_data = '0;
        push_data.tag = s2.tag;
        if (s2.legal) begin
            push_data.result = alu_Result;
            push_data.error  = alu_Error & ~err_seen;
        end else begin
            push_data.result = '0;
            push_data.error  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_seen     <= 1'b0;
            illegal_seen <= 1'b0;
        end else if (push) begin
            if (s2.legal) begin
                err_seen <= err_seen | alu_Error;
            end else begin
                illegal_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            credits <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            case ({accept, pop})
                2'b10:   credits <= credits + PW'(1);
                2'b01:   credits <= credits - PW'(1);
                default: credits <= credits;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
`timescale 1ns/1ps
// Self-checking bench for alu_req_driver: ALU stub plus an in-order response queue model.
module tb_alu_req_driver;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam logic [2:0]  IDLE_OP = 3'b010;
    localparam longint      MAX_S32 = 64'sd2147483647;
    localparam longint      MIN_S32 = -64'sd2147483648;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [2:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      alu_A;
    logic [31:0]      alu_B;
    logic [2:0]       alu_opcode;
    logic [31:0]      alu_Result;
    logic             alu_Error;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_error;
    logic [TAG_W-1:0] rsp_tag;
    logic             err_sticky;

    typedef struct packed {
        logic [31:0]      result;
        logic             error;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    logic m_ovf;
    int   passed;
    int   total;

    alu_req_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDLE_OP(IDLE_OP)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
        .alu_Result(alu_Result), .alu_Error(alu_Error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_tag(rsp_tag),
        .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: registered result, sticky error on signed add/sub overflow.
    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        logic [31:0] r;
        logic        o;
        r = '0;
        o = 1'b0;
        case (op)
            3'd0: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    logic [32:0] alu_next;
    always_comb alu_next = alu_f(alu_A, alu_B, alu_opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_Result <= '0;
            alu_Error  <= 1'b0;
        end else begin
            alu_Result <= alu_next[31:0];
            alu_Error  <= alu_Error | alu_next[32];
        end
    end

    // Reference: what response an accepted command must eventually produce.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input logic [TAG_W-1:0] tag);
        longint s;
        logic   ovf;
        exp_t   e;
        s   = 0;
        ovf = 1'b0;
        e.tag = tag;
        if (op > 3'd4) begin
            e.result = '0;
            e.error  = 1'b1;
        end else begin
            case (op)
                3'd0:    s = longint'($signed(a)) + longint'($signed(b));
                3'd1:    s = longint'($signed(a)) - longint'($signed(b));
                3'd2:    s = longint'(a & b);
                3'd3:    s = longint'(a | b);
                default: s = longint'(a ^ b);
            endcase
            ovf      = (op <= 3'd1) && ((s > MAX_S32) || (s < MIN_S32));
            e.result = s[31:0];
            e.error  = ovf && !m_ovf;
            m_ovf    = m_ovf | ovf;
        end
        q.push_back(e);
    endtask

    task automatic drive_cmd(input logic v, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [TAG_W-1:0] tag);
        cmd_valid = v;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_cmd(1'b0, '0, '0, 3'd0, '0);
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({alu_A, alu_B, alu_opcode} !== {32'd0, 32'd0, IDLE_OP}) begin
            $display("FAIL reset_alu: got %h/%h/%b exp 0/0/%b", alu_A, alu_B, alu_opcode, IDLE_OP);
        end else passed++;
        total++;
        if ({rsp_valid, cmd_ready, err_sticky} !== 3'b010) begin
            $display("FAIL reset_flags: got valid/ready/sticky=%b%b%b exp 010", rsp_valid, cmd_ready, err_sticky);
        end else passed++;
        total++;
        if ({rsp_result, rsp_error, rsp_tag} !== '0) begin
            $display("FAIL reset_rsp: got %h/%b/%h exp zeros", rsp_result, rsp_error, rsp_tag);
        end else passed++;
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_add();
        exp_t got;
        rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'd5, 32'd7, 3'd0, 4'd3);
        total++;
        if (cmd_ready !== 1'b1) $display("FAIL add_ready: got %b exp 1", cmd_ready);
        else passed++;
        model_accept(cmd_a, cmd_b, cmd_op, cmd_tag);
        @(negedge clk);
        drive_cmd(1'b0, '0, '0, 3'd0, '0);
        total++;
        if ({alu_A, alu_B, alu_opcode, rsp_valid} !== {32'd5, 32'd7, 3'd0, 1'b0}) begin
            $display("FAIL add_issue: got %h/%h/%b valid=%b exp 5/7/000 valid=0", alu_A, alu_B, alu_opcode, rsp_valid);
        end else passed++;
        @(negedge clk);
        total++;
        if ({rsp_valid, alu_opcode} !== {1'b0, IDLE_OP}) begin
            $display("FAIL add_edge1: got valid=%b op=%b exp valid=0 op=%b", rsp_valid, alu_opcode, IDLE_OP);
        end else passed++;
        @(negedge clk);
        got = {rsp_result, rsp_error, rsp_tag};
        total++;
        if (rsp_valid !== 1'b1 || got !== q[0]) begin
            $display("FAIL add_rsp: got valid=%b %h exp valid=1 %h", rsp_valid, got, q[0]);
        end else passed++;
        void'(q.pop_front());
        total++;
        if (err_sticky !== 1'b0) $display("FAIL add_sticky: got %b exp 0", err_sticky);
        else passed++;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL add_popped: got valid=%b exp 0", rsp_valid);
        else passed++;
    endtask

    task automatic test_overflow();
        exp_t got;
        int   n;
        rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h7FFF_FFFF, 32'd1, 3'd0, 4'd1);
        model_accept(cmd_a, cmd_b, cmd_op, cmd_tag);
        @(negedge clk);
        drive_cmd(1'b1, 32'h0000_00F0, 32'h0000_00FF, 3'd4, 4'd2);
        model_accept(cmd_a, cmd_b, cmd_op, cmd_tag);
        @(negedge clk);
        drive_cmd(1'b0, '0, '0, 3'd0, '0);
        n = 0;
        while (q.size() > 0 && n < 12) begin
            if (rsp_valid === 1'b1) begin
                got = {rsp_result, rsp_error, rsp_tag};
                total++;
                if (got !== q[0]) $display("FAIL ovf_rsp: got %h exp %h", got, q[0]);
                else passed++;
                void'(q.pop_front());
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) $display("FAIL ovf_timeout: %0d responses missing exp 0", q.size());
        else passed++;
        total++;
        if (err_sticky !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", err_sticky);
        else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t       got;
        int         accepts;
        int         n;
        logic [3:0] tag;
        logic [3:0] rdy_tab;
        logic [3:0] vld_tab;
        rdy_tab   = 4'b0011;
        vld_tab   = 4'b1110;
        tag       = '0;
        accepts   = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_cmd(1'b1, $urandom, $urandom, 3'd2, tag);
            total++;
            if (cmd_ready !== (q.size() < DEPTH)) $display("FAIL bp_ready_fill: got %b exp %b", cmd_ready, q.size() < DEPTH);
            else passed++;
            if (cmd_ready === 1'b1) begin
                model_accept(cmd_a, cmd_b, cmd_op, cmd_tag);
                tag++;
                accepts++;
            end
            @(negedge clk);
        end
        total++;
        if (accepts != DEPTH || cmd_ready !== 1'b0) begin
            $display("FAIL bp_accepts: got %0d ready=%b exp %0d ready=0", accepts, cmd_ready, DEPTH);
        end else passed++;
        // Pop-only, then pop+accept, then accept-only; credits must reach DEPTH exactly once.
        for (int k = 0; k < 4; k++) begin
            rsp_ready = rdy_tab[k];
            drive_cmd(vld_tab[k], $urandom, $urandom, 3'd2, tag);
            total++;
            if (cmd_ready !== (q.size() < DEPTH)) $display("FAIL bp_ready_step%0d: got %b exp %b", k, cmd_ready, q.size() < DEPTH);
            else passed++;
            if (rsp_valid === 1'b1 && rsp_ready) begin
                got = {rsp_result, rsp_error, rsp_tag};
                total++;
                if (got !== q[0]) $display("FAIL bp_rsp_step%0d: got %h exp %h", k, got, q[0]);
                else passed++;
                void'(q.pop_front());
            end
            if (cmd_valid && cmd_ready === 1'b1) begin
                model_accept(cmd_a, cmd_b, cmd_op, cmd_tag);
                tag++;
            end
            @(negedge clk);
        end
        drive_cmd(1'b0, '0, '0, 3'd0, '0);
        rsp_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            if (rsp_valid === 1'b1) begin
                got = {rsp_result, rsp_error, rsp_tag};
                total++;
                if (got !== q[0]) $display("FAIL bp_drain: got %h exp %h", got, q[0]);
                else passed++;
                void'(q.pop_front());
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0 || cmd_ready !== 1'b1) $display("FAIL bp_timeout: left %0d ready=%b exp 0 ready=1", q.size(), cmd_ready);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1'b1, $urandom, $urandom, 3'd3, 4'(i + 9));
            model_accept(cmd_a, cmd_b, cmd_op, cmd_tag);
            @(negedge clk);
        end
        drive_cmd(1'b0, '0, '0, 3'd0, '0);
        total++;
        if ({rsp_valid, err_sticky} !== 2'b11) $display("FAIL mid_pre: got valid/sticky=%b%b exp 11", rsp_valid, err_sticky);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready, alu_opcode, err_sticky} !== {1'b0, 1'b1, IDLE_OP, 1'b0}) begin
            $display("FAIL mid_reset: got valid=%b ready=%b op=%b sticky=%b exp 0 1 %b 0", rsp_valid, cmd_ready, alu_opcode, err_sticky, IDLE_OP);
        end else passed++;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_result, rsp_tag} !== '0) $display("FAIL mid_dropped%0d: got valid=%b %h/%h exp zeros", i, rsp_valid, rsp_result, rsp_tag);
            else passed++;
        end
    endtask

    task automatic test_illegal();
        exp_t got;
        int   n;
        rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 3'b110, 4'd7);
        model_accept(cmd_a, cmd_b, cmd_op, cmd_tag);
        @(negedge clk);
        total++;
        if ({alu_A, alu_B, alu_opcode} !== {32'd0, 32'd0, IDLE_OP}) begin
            $display("FAIL ill_issue: got %h/%h/%b exp 0/0/%b", alu_A, alu_B, alu_opcode, IDLE_OP);
        end else passed++;
        drive_cmd(1'b1, 32'd2, 32'd2, 3'd0, 4'd8);
        model_accept(cmd_a, cmd_b, cmd_op, cmd_tag);
        @(negedge clk);
        drive_cmd(1'b0, '0, '0, 3'd0, '0);
        total++;
        if (alu_opcode !== 3'd0) $display("FAIL ill_next_issue: got %b exp 000", alu_opcode);
        else passed++;
        n = 0;
        while (q.size() > 0 && n < 12) begin
            total++;
            if (alu_opcode === 3'b110) $display("FAIL ill_opcode: got 110 exp never");
            else passed++;
            if (rsp_valid === 1'b1) begin
                got = {rsp_result, rsp_error, rsp_tag};
                total++;
                if (got !== q[0]) $display("FAIL ill_rsp: got %h exp %h", got, q[0]);
                else passed++;
                void'(q.pop_front());
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0 || err_sticky !== 1'b1) $display("FAIL ill_end: left %0d sticky=%b exp 0 sticky=1", q.size(), err_sticky);
        else passed++;
    endtask

    task automatic test_random();
        exp_t        got;
        int          accepted;
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        accepted = 0;
        n = 0;
        while ((accepted < 20 || q.size() > 0) && n < 600) begin
            a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)) : $urandom;
            drive_cmd((accepted < 20) && ($urandom_range(0, 3) != 0), a, b,
                      3'($urandom_range(0, 4)), 4'($urandom));
            rsp_ready = 1'($urandom_range(0, 1));
            total++;
            if (cmd_ready !== (q.size() < DEPTH)) $display("FAIL rnd_ready: got %b exp %b", cmd_ready, q.size() < DEPTH);
            else passed++;
            if (rsp_valid === 1'b1 && rsp_ready) begin
                got = {rsp_result, rsp_error, rsp_tag};
                total++;
                if (q.size() == 0 || got !== q[0]) $display("FAIL rnd_rsp: got %h exp %h (queued %0d)", got, (q.size() > 0) ? q[0] : '0, q.size());
                else passed++;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (cmd_valid && cmd_ready === 1'b1) begin
                model_accept(cmd_a, cmd_b, cmd_op, cmd_tag);
                accepted++;
            end
            @(negedge clk);
            n++;
        end
        drive_cmd(1'b0, '0, '0, 3'd0, '0);
        total++;
        if (accepted != 20 || q.size() != 0) $display("FAIL rnd_timeout: accepted %0d left %0d exp 20 and 0", accepted, q.size());
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        m_ovf  = 1'b0;
        test_reset();
        test_basic_add();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
